// File: rtl/food_spawner.sv
// Food cell picker: hashes candidates from seed+index, skips off-grid cells, probes occupancy, returns first free cell.
// Latency: accept at T, first-try hit gives food_valid at T+4; +3 per on-grid retry, +1 per off-grid retry.
// Backpressure: spawn_ready only in IDLE, requests while busy are dropped. Build option LINEAR_FALLBACK_EN adds a raster scan after the hashed tries.
module food_spawner #(
    parameter int GRID_W    = 16,
    parameter int GRID_H    = 12,
    parameter int MAX_TRIES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seed,
    input  logic       spawn_req,
    output logic       spawn_ready,
    output logic       occ_rd,
    output logic [3:0] occ_x,
    output logic [3:0] occ_y,
    input  logic       occ_hit,
    output logic       food_valid,
    output logic [3:0] food_x,
    output logic [3:0] food_y,
    output logic       spawn_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_QUERY,
        S_CHECK,
        S_DONE,
        S_FAIL
    } state_t;

    state_t      state_q;
    logic [7:0]  seed_q;
    logic [31:0] idx_q;
    logic [7:0]  tries_q;
    logic        occ_rd_q;
    logic [3:0]  occ_x_q;
    logic [3:0]  occ_y_q;
    logic        food_valid_q;
    logic [3:0]  food_x_q;
    logic [3:0]  food_y_q;
    logic        spawn_fail_q;
`ifdef LINEAR_FALLBACK_EN
    logic        scan_q;
    logic [8:0]  cells_q;
    logic [3:0]  scan_x_d;
    logic [3:0]  scan_y_d;
`endif

    // Only the low 16 index bits feed the fold; the rest only keep the counter 32-bit wide.
    logic       idx_unused;
    logic [3:0] fold_d;
    logic [7:0] hd_d;
    logic [7:0] ha_d;
    logic [7:0] hb_d;
    logic [7:0] h_d;
    logic       on_grid_d;
    logic [7:0] tries_inc_d;

    assign idx_unused  = ^idx_q[31:16];
    assign fold_d      = idx_q[3:0] ^ idx_q[7:4] ^ idx_q[11:8] ^ idx_q[15:12];
    assign hd_d        = seed_q ^ {4'b0000, fold_d};
    assign ha_d        = hd_d ^ (hd_d << 3);
    assign hb_d        = ha_d ^ (ha_d >> 5);
    assign h_d         = hb_d ^ (hb_d << 2);
    assign on_grid_d   = (5'(h_d[3:0]) < 5'(GRID_W)) && (5'(h_d[7:4]) < 5'(GRID_H));
    assign tries_inc_d = tries_q + 8'd1;

`ifdef LINEAR_FALLBACK_EN
    always_comb begin
        scan_x_d = occ_x_q + 4'd1;
        scan_y_d = occ_y_q;
        if (occ_x_q == 4'(GRID_W - 1)) begin
            scan_x_d = 4'd0;
            scan_y_d = (occ_y_q == 4'(GRID_H - 1)) ? 4'd0 : occ_y_q + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            seed_q       <= 8'd0;
            idx_q        <= 32'd0;
            tries_q      <= 8'd0;
            occ_rd_q     <= 1'b0;
            occ_x_q      <= 4'd0;
            occ_y_q      <= 4'd0;
            food_valid_q <= 1'b0;
            food_x_q     <= 4'd0;
            food_y_q     <= 4'd0;
            spawn_fail_q <= 1'b0;
`ifdef LINEAR_FALLBACK_EN
            scan_q       <= 1'b0;
            cells_q      <= 9'd0;
`endif
        end else begin
            occ_rd_q     <= 1'b0;
            food_valid_q <= 1'b0;
            spawn_fail_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (spawn_req) begin
                        seed_q  <= seed;
                        tries_q <= 8'd0;
                        state_q <= S_GEN;
`ifdef LINEAR_FALLBACK_EN
                        scan_q  <= 1'b0;
`endif
                    end
                end
                S_GEN: begin
                    idx_q   <= idx_q + 32'd1;
                    tries_q <= tries_inc_d;
                    if (on_grid_d) begin
                        occ_rd_q <= 1'b1;
                        occ_x_q  <= h_d[3:0];
                        occ_y_q  <= h_d[7:4];
                        state_q  <= S_QUERY;
                    end else if (tries_inc_d == 8'(MAX_TRIES)) begin
`ifdef LINEAR_FALLBACK_EN
                        // Off-grid last candidate: scan starts from the origin.
                        scan_q   <= 1'b1;
                        cells_q  <= 9'd0;
                        occ_rd_q <= 1'b1;
                        occ_x_q  <= 4'd0;
                        occ_y_q  <= 4'd0;
                        state_q  <= S_QUERY;
`else
                        spawn_fail_q <= 1'b1;
                        state_q      <= S_FAIL;
`endif
                    end
                end
                S_QUERY: state_q <= S_CHECK;
                S_CHECK: begin
                    if (!occ_hit) begin
                        food_x_q     <= occ_x_q;
                        food_y_q     <= occ_y_q;
                        food_valid_q <= 1'b1;
                        state_q      <= S_DONE;
`ifdef LINEAR_FALLBACK_EN
                    end else if (scan_q) begin
                        if (cells_q == 9'(GRID_W * GRID_H - 1)) begin
                            spawn_fail_q <= 1'b1;
                            state_q      <= S_FAIL;
                        end else begin
                            cells_q  <= cells_q + 9'd1;
                            occ_rd_q <= 1'b1;
                            occ_x_q  <= scan_x_d;
                            occ_y_q  <= scan_y_d;
                            state_q  <= S_QUERY;
                        end
`endif
                    end else if (tries_q == 8'(MAX_TRIES)) begin
`ifdef LINEAR_FALLBACK_EN
                        // Scan begins by re-probing the last on-grid candidate.
                        scan_q   <= 1'b1;
                        cells_q  <= 9'd0;
                        occ_rd_q <= 1'b1;
                        state_q  <= S_QUERY;
`else
                        spawn_fail_q <= 1'b1;
                        state_q      <= S_FAIL;
`endif
                    end else begin
                        state_q <= S_GEN;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                S_FAIL:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign spawn_ready = (state_q == S_IDLE);
    assign occ_rd      = occ_rd_q;
    assign occ_x       = occ_x_q;
    assign occ_y       = occ_y_q;
    assign food_valid  = food_valid_q;
    assign food_x      = food_x_q;
    assign food_y      = food_y_q;
    assign spawn_fail  = spawn_fail_q;

endmodule

// File: tb/tb_food_spawner.sv
// Directed bench for food_spawner (GRID 16x12, MAX_TRIES=4); occupancy store answers one cycle after occ_rd.
module tb_food_spawner;

    logic       clk;
    logic       rst_n;
    logic [7:0] seed;
    logic       spawn_req;
    logic       spawn_ready;
    logic       occ_rd;
    logic [3:0] occ_x;
    logic [3:0] occ_y;
    logic       occ_hit;
    logic       food_valid;
    logic [3:0] food_x;
    logic [3:0] food_y;
    logic       spawn_fail;

    int n_cmp = 0;
    int n_bad = 0;

    logic occ_map [256];
    logic pend_rd;
    logic pend_hit;
    logic noise;
    int   rd_cnt;
    int   fv_cnt;
    int   sf_cnt;
    logic [3:0] last_x;
    logic [3:0] last_y;

    food_spawner #(.GRID_W(16), .GRID_H(12), .MAX_TRIES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seed        (seed),
        .spawn_req   (spawn_req),
        .spawn_ready (spawn_ready),
        .occ_rd      (occ_rd),
        .occ_x       (occ_x),
        .occ_y       (occ_y),
        .occ_hit     (occ_hit),
        .food_valid  (food_valid),
        .food_x      (food_x),
        .food_y      (food_y),
        .spawn_fail  (spawn_fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Occupancy store model plus event counters, sampled mid-cycle.
    always @(negedge clk) begin
        pend_rd  = occ_rd;
        pend_hit = occ_map[{occ_y, occ_x}];
        if (occ_rd === 1'b1) begin
            rd_cnt = rd_cnt + 1;
            last_x = occ_x;
            last_y = occ_y;
        end
        if (food_valid === 1'b1) fv_cnt = fv_cnt + 1;
        if (spawn_fail === 1'b1) sf_cnt = sf_cnt + 1;
    end

    always @(posedge clk) begin
        #1;
        occ_hit = pend_rd ? pend_hit : noise;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_map(input logic v);
        for (int i = 0; i < 256; i++) occ_map[i] = v;
    endtask

    task automatic clear_counts();
        rd_cnt = 0;
        fv_cnt = 0;
        sf_cnt = 0;
    endtask

    task automatic do_reset();
        spawn_req = 1'b0;
        rst_n     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic accept(input logic [7:0] s);
        seed      = s;
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
        seed      = ~s;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({spawn_ready, occ_rd, food_valid, spawn_fail, occ_x, occ_y, food_x, food_y} !== {4'b1000, 16'h0000}) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b rd=%b fv=%b sf=%b occ=(%0d,%0d) food=(%0d,%0d) want rdy=1 others 0",
                     spawn_ready, occ_rd, food_valid, spawn_fail, occ_x, occ_y, food_x, food_y);
        end
    endtask

    // seed=1, idx=0 -> (13,2) free; occ_hit noise outside CHECK must not matter.
    task automatic test_first_try();
        clear_map(1'b0);
        noise = 1'b1;
        accept(8'h01);
        n_cmp++;
        if ({occ_rd, spawn_ready} !== 2'b00) begin
            n_bad++;
            $display("FAIL first_gen: got rd=%b rdy=%b want rd=0 rdy=0", occ_rd, spawn_ready);
        end
        tick();
        n_cmp++;
        if ({occ_rd, occ_x, occ_y} !== {1'b1, 4'd13, 4'd2}) begin
            n_bad++;
            $display("FAIL first_query: got rd=%b (%0d,%0d) want rd=1 (13,2)", occ_rd, occ_x, occ_y);
        end
        tick();
        tick();
        n_cmp++;
        if ({food_valid, food_x, food_y} !== {1'b1, 4'd13, 4'd2}) begin
            n_bad++;
            $display("FAIL first_food: got fv=%b (%0d,%0d) want fv=1 (13,2) at T+4", food_valid, food_x, food_y);
        end
        tick();
        noise = 1'b0;
        n_cmp++;
        if ({food_valid, spawn_ready, food_x, food_y} !== {1'b0, 1'b1, 4'd13, 4'd2}) begin
            n_bad++;
            $display("FAIL first_after: got fv=%b rdy=%b (%0d,%0d) want fv=0 rdy=1 held (13,2)",
                     food_valid, spawn_ready, food_x, food_y);
        end
    endtask

    // (13,2) occupied -> idx=1 gives (0,0); busy-time req/seed changes ignored.
    task automatic test_retry();
        do_reset();
        clear_map(1'b0);
        occ_map[{4'd2, 4'd13}] = 1'b1;
        clear_counts();
        accept(8'h01);
        tick();
        tick();
        spawn_req = 1'b1;
        seed      = 8'h55;
        tick();
        n_cmp++;
        if (food_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL retry_no_early_food: got fv=%b want 0 at T+4", food_valid);
        end
        tick();
        n_cmp++;
        if ({occ_rd, occ_x, occ_y} !== {1'b1, 4'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL retry_query2: got rd=%b (%0d,%0d) want rd=1 (0,0) at T+5", occ_rd, occ_x, occ_y);
        end
        tick();
        spawn_req = 1'b0;
        tick();
        n_cmp++;
        if ({food_valid, food_x, food_y} !== {1'b1, 4'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL retry_food: got fv=%b (%0d,%0d) want fv=1 (0,0) at T+7", food_valid, food_x, food_y);
        end
        tick();
        tick();
        n_cmp++;
        if ({spawn_ready, rd_cnt, fv_cnt} !== {1'b1, 32'd2, 32'd1}) begin
            n_bad++;
            $display("FAIL retry_no_queue: got rdy=%b lookups=%0d foods=%0d want rdy=1 lookups=2 foods=1",
                     spawn_ready, rd_cnt, fv_cnt);
        end
    endtask

    // seed=0: idx 0..5 all on-grid, then idx 6 (11,14) and 7 (6,12) are off-grid, idx 8 gives (2,6).
    task automatic test_offgrid();
        logic [3:0] ex [6];
        logic [3:0] ey [6];
        ex = '{4'd0, 4'd13, 4'd10, 4'd7, 4'd1, 4'd12};
        ey = '{4'd0, 4'd2,  4'd5,  4'd7, 4'd11, 4'd9};
        do_reset();
        clear_map(1'b0);
        for (int k = 0; k < 6; k++) begin
            accept(8'h00);
            repeat (3) tick();
            n_cmp++;
            if ({food_valid, food_x, food_y} !== {1'b1, ex[k], ey[k]}) begin
                n_bad++;
                $display("FAIL hash_idx%0d: got fv=%b (%0d,%0d) want fv=1 (%0d,%0d)",
                         k, food_valid, food_x, food_y, ex[k], ey[k]);
            end
            tick();
        end
        clear_counts();
        accept(8'h00);
        tick();
        tick();
        n_cmp++;
        if (rd_cnt !== 0) begin
            n_bad++;
            $display("FAIL offgrid_no_lookup: got %0d lookups in T+1..T+3 want 0", rd_cnt);
        end
        tick();
        n_cmp++;
        if ({occ_rd, occ_x, occ_y} !== {1'b1, 4'd2, 4'd6}) begin
            n_bad++;
            $display("FAIL offgrid_query: got rd=%b (%0d,%0d) want rd=1 (2,6) at T+4", occ_rd, occ_x, occ_y);
        end
        tick();
        tick();
        n_cmp++;
        if ({food_valid, food_x, food_y} !== {1'b1, 4'd2, 4'd6}) begin
            n_bad++;
            $display("FAIL offgrid_food: got fv=%b (%0d,%0d) want fv=1 (2,6) at T+6", food_valid, food_x, food_y);
        end
        tick();
    endtask

    // Full board, idx 9..12: (15,4),(8,3),(5,1) probed, (3,13) off-grid exhausts.
    task automatic test_exhaust();
        int c;
        int exp_c;
        int exp_rd;
        logic [3:0] exp_x;
        logic [3:0] exp_y;
`ifdef LINEAR_FALLBACK_EN
        exp_c = 395; exp_rd = 195; exp_x = 4'd15; exp_y = 4'd11;
`else
        exp_c = 11;  exp_rd = 3;   exp_x = 4'd5;  exp_y = 4'd1;
`endif
        clear_map(1'b1);
        clear_counts();
        accept(8'h00);
        c = 1;
        while (spawn_fail !== 1'b1 && c < 600) begin
            tick();
            c++;
        end
        n_cmp++;
        if (c !== exp_c) begin
            n_bad++;
            $display("FAIL exhaust_latency: got spawn_fail at T+%0d want T+%0d", c, exp_c);
        end
        n_cmp++;
        if ({rd_cnt, fv_cnt, last_x, last_y} !== {exp_rd, 32'd0, exp_x, exp_y}) begin
            n_bad++;
            $display("FAIL exhaust_lookups: got lookups=%0d foods=%0d last=(%0d,%0d) want %0d 0 (%0d,%0d)",
                     rd_cnt, fv_cnt, last_x, last_y, exp_rd, exp_x, exp_y);
        end
        tick();
        n_cmp++;
        if ({spawn_fail, spawn_ready, sf_cnt} !== {1'b0, 1'b1, 32'd1}) begin
            n_bad++;
            $display("FAIL exhaust_pulse: got sf=%b rdy=%b pulses=%0d want sf=0 rdy=1 pulses=1",
                     spawn_fail, spawn_ready, sf_cnt);
        end
    endtask

`ifdef LINEAR_FALLBACK_EN
    // Only (5,7) free; hashed (0,0),(13,2),(10,5),(7,7) hit, scan from (7,7) reaches (5,7) as cell 191.
    task automatic test_scan();
        int c;
        do_reset();
        clear_map(1'b1);
        occ_map[{4'd7, 4'd5}] = 1'b0;
        clear_counts();
        accept(8'h00);
        c = 1;
        while (food_valid !== 1'b1 && spawn_fail !== 1'b1 && c < 600) begin
            tick();
            c++;
        end
        n_cmp++;
        if ({food_valid, food_x, food_y} !== {1'b1, 4'd5, 4'd7} || c !== 395) begin
            n_bad++;
            $display("FAIL scan_food: got fv=%b (%0d,%0d) at T+%0d want fv=1 (5,7) at T+395",
                     food_valid, food_x, food_y, c);
        end
        n_cmp++;
        if ({rd_cnt, sf_cnt} !== {32'd195, 32'd0}) begin
            n_bad++;
            $display("FAIL scan_lookups: got lookups=%0d fails=%0d want 195 0", rd_cnt, sf_cnt);
        end
        tick();
    endtask
`endif

    // Async reset in QUERY with spawn_req held; accept resumes on first edge after release.
    task automatic test_reset_mid();
        do_reset();
        clear_map(1'b0);
        accept(8'h01);
        repeat (4) tick();
        seed      = 8'h03;
        spawn_req = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({occ_rd, occ_x, occ_y, food_x, food_y} !== {1'b1, 4'd10, 4'd5, 4'd13, 4'd2}) begin
            n_bad++;
            $display("FAIL mid_setup: got rd=%b occ=(%0d,%0d) food=(%0d,%0d) want 1 (10,5) (13,2)",
                     occ_rd, occ_x, occ_y, food_x, food_y);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({spawn_ready, occ_rd, food_valid, spawn_fail, occ_x, occ_y, food_x, food_y} !== {4'b1000, 16'h0000}) begin
            n_bad++;
            $display("FAIL mid_reset_clear: got rdy=%b rd=%b fv=%b sf=%b occ=(%0d,%0d) food=(%0d,%0d) want rdy=1 others 0",
                     spawn_ready, occ_rd, food_valid, spawn_fail, occ_x, occ_y, food_x, food_y);
        end
        #1;
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (spawn_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reaccept: got rdy=%b want 0 after first edge", spawn_ready);
        end
        spawn_req = 1'b0;
        tick();
        n_cmp++;
        if ({occ_rd, occ_x, occ_y} !== {1'b1, 4'd7, 4'd7}) begin
            n_bad++;
            $display("FAIL mid_requery: got rd=%b (%0d,%0d) want rd=1 (7,7)", occ_rd, occ_x, occ_y);
        end
        tick();
        tick();
        n_cmp++;
        if ({food_valid, food_x, food_y} !== {1'b1, 4'd7, 4'd7}) begin
            n_bad++;
            $display("FAIL mid_food: got fv=%b (%0d,%0d) want fv=1 (7,7)", food_valid, food_x, food_y);
        end
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        seed      = 8'h00;
        spawn_req = 1'b0;
        occ_hit   = 1'b0;
        noise     = 1'b0;
        pend_rd   = 1'b0;
        pend_hit  = 1'b0;
        last_x    = 4'd0;
        last_y    = 4'd0;
        clear_counts();
        clear_map(1'b0);
        test_reset();
        test_first_try();
        test_retry();
        test_offgrid();
        test_exhaust();
`ifdef LINEAR_FALLBACK_EN
        test_scan();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1);
    end

endmodule
